song_player: RTL and testbench
==============================

SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 The module SHALL have parameter TICKS_PER_BEAT, default 25_000_000, meaning clk cycles per beat (>=4).
REQ-002 The module SHALL have parameter GAP_TICKS, default 2_500_000, meaning silent cycles at the end of each note (< TICKS_PER_BEAT).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port enable, input, 1 bit: auto-play mode active (mode bit 010).
REQ-006 The module SHALL have port song_select, input, 2 bits: bit1 selects next song, bit0 selects previous song; raw button levels.
REQ-007 The module SHALL have port note_out, output, 4 bits: note for the buzzer, 0 = rest, 1..7 = do..si.
REQ-008 The module SHALL have port led_out, output, 7 bits: one-hot led_out[note_out-1] when note_out is 1..7, else 0.
REQ-009 The module SHALL have port song_idx, output, 2 bits: current song number.
REQ-010 The module SHALL have port playing, output, 1 bit: high in PLAY or GAP.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse on song completion.

Function
REQ-012 The module SHALL contain a constant ROM of 4 songs x 32 entries; each entry is {note[3:0], dur[1:0]}, duration = dur+1 beats, note 4'hF = end marker.
REQ-013 The module SHALL pass each song_select bit through a 2-flop synchronizer and act only on its rising edge.
REQ-014 A next edge SHALL increment song_idx mod 4 (3->0); a prev edge SHALL decrement it mod 4 (0->3); simultaneous next and prev edges SHALL be ignored.
REQ-015 A song change while enable=1 SHALL restart at entry 0 of the new song in PLAY on the following cycle, aborting the current note.
REQ-016 The FSM SHALL have states IDLE, PLAY, GAP and DONE.
REQ-017 IDLE SHALL go to PLAY at entry 0 when enable=1; any state SHALL go to IDLE within 1 cycle when enable=0; position is not retained.
REQ-018 On entering PLAY, the module SHALL fetch the entry; note_out SHALL equal the entry note one cycle later (registered, 1-cycle latency).
REQ-019 The module SHALL stay in PLAY for (dur+1)*TICKS_PER_BEAT - GAP_TICKS cycles, then in GAP (note_out=0) for GAP_TICKS cycles, then advance the address and return to PLAY.
REQ-020 An end-marker fetch SHALL drive note_out=0 and go to DONE; address 31 without a marker SHALL be treated as an end marker.
REQ-021 The done pulse SHALL be asserted for exactly one cycle on entry to DONE.
REQ-022 DONE SHALL be held until enable=0 or a song change.
REQ-023 Note values 8..14 in the ROM SHALL be output as 0 (rest) with normal duration.
REQ-024 The duration counter SHALL be wide enough for 4*TICKS_PER_BEAT without overflow.

Reset
REQ-025 While reset=0, the module SHALL hold state IDLE, song_idx=0, address=0, counters=0, note_out=0, led_out=0, playing=0, done=0, and synchronizer flops=0.
REQ-026 Reset asserted mid-note SHALL silence note_out immediately (asynchronously).
REQ-027 After reset release with enable=1, playback SHALL start at song 0 entry 0.

Configuration
REQ-028 The macro SONG_LOOP_EN, when defined, SHALL make an end marker restart the same song at entry 0 (PLAY, no done pulse, no DONE state).
REQ-029 When SONG_LOOP_EN is undefined, end-of-song behaviour SHALL follow REQ-020 to REQ-022.

Verification (TICKS_PER_BEAT=8, GAP_TICKS=2)
REQ-030 Song 0 entry0 {3,dur=1}, enable rises -> note_out=3 for 14 cycles, 0 for 2, then entry1 note.
REQ-031 Song with 2 notes then marker -> done high exactly 1 cycle, note_out=0 and playing=0 thereafter; with SONG_LOOP_EN, entry0 note repeats and done is never set.
REQ-032 song_idx=3, next pulse -> song_idx=0 and song 0 restarts at entry 0; song_idx=0, prev pulse -> song_idx=3; both bits rising on the same cycle -> song_idx unchanged.
REQ-033 enable dropped mid-note -> note_out=0 and IDLE within 1 cycle; re-enable -> entry 0 replayed.
REQ-034 reset=0 asserted during GAP in song 2 -> all outputs 0 immediately, song_idx=0 after release.
REQ-035 note_out=5 -> led_out=7'b0010000; note 9 in ROM -> note_out=0 and led_out=0 for the entry's duration.

Source files
------------

// File: rtl/song_player.sv
// ---------------------------------------------------------------------------
// song_player
//
// Plays one of four fixed songs from an internal ROM to a buzzer and a
// 7-LED bar. Each ROM entry is {note[3:0], dur[1:0]}: the note sounds for
// (dur+1) beats minus a short silent gap, then the next entry is fetched.
// Note 4'hF marks the end of a song. Address 31 also ends the song.
// Notes 8..14 are played as rests that keep their normal length.
//
// Parameters
//   TICKS_PER_BEAT  clk cycles per beat (>= 4)
//   GAP_TICKS       silent cycles closing every note (1 .. TICKS_PER_BEAT-1)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       auto-play mode; low forces IDLE and forgets the position
//   song_select  raw buttons: bit1 = next song, bit0 = previous song
//   note_out     registered buzzer note, 0 = rest, 1..7 = do..si
//   led_out      one-hot led_out[note_out-1] for notes 1..7, else 0
//   song_idx     current song number
//   playing      high while in PLAY or GAP
//   done         one-cycle pulse when a song finishes
//   state_dbg    current FSM state (IDLE=0, PLAY=1, GAP=2, DONE=3)
//
// Build option
//   SONG_LOOP_EN  when defined, an end marker restarts the same song at
//                 entry 0 instead of stopping in DONE.
//
// Button handshake: a button press is recognised on the rising edge of its
// synchronised level; no acknowledge is returned. Pressing next and prev on
// the same cycle is treated as no press.
// ---------------------------------------------------------------------------
module song_player #(
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int GAP_TICKS      = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] song_select,
  output logic [3:0] note_out,
  output logic [6:0] led_out,
  output logic [1:0] song_idx,
  output logic       playing,
  output logic       done,
  output logic [1:0] state_dbg
);

  // Wide enough to hold the longest note (4 beats).
  localparam int CW = $clog2(4 * TICKS_PER_BEAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [4:0]      addr, addr_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      note_nx;
  logic            done_nx;

  // Button synchronisers; sync3 holds the previous synchronised level.
  logic [1:0] sync1, sync2, sync3;
  logic [1:0] rise;
  logic       next_edge, prev_edge, change;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      sync3 <= 2'b00;
    end else begin
      sync1 <= song_select;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise      = sync2 & ~sync3;
  assign next_edge = rise[1] & ~rise[0];
  assign prev_edge = rise[0] & ~rise[1];
  assign change    = next_edge | prev_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song_idx <= 2'd0;
    end else if (next_edge) begin
      song_idx <= song_idx + 2'd1;
    end else if (prev_edge) begin
      song_idx <= song_idx - 2'd1;
    end
  end

  // Song ROM. Unlisted locations read as end markers.
  function automatic logic [5:0] rom_entry(input logic [1:0] song,
                                           input logic [4:0] a);
    logic [5:0] r;
    r = {4'hF, 2'd0};
    case ({song, a})
      {2'd0, 5'd0}: r = {4'd3,  2'd1};
      {2'd0, 5'd1}: r = {4'd5,  2'd0};
      {2'd0, 5'd2}: r = {4'd1,  2'd0};
      {2'd0, 5'd3}: r = {4'd7,  2'd2};
      {2'd1, 5'd0}: r = {4'd2,  2'd0};
      {2'd1, 5'd1}: r = {4'd4,  2'd0};
      {2'd2, 5'd0}: r = {4'd9,  2'd0};
      {2'd2, 5'd1}: r = {4'd6,  2'd1};
      {2'd2, 5'd2}: r = {4'd8,  2'd0};
      {2'd2, 5'd3}: r = {4'd1,  2'd0};
      {2'd3, 5'd0}: r = {4'd5,  2'd0};
      {2'd3, 5'd1}: r = {4'd7,  2'd3};
      {2'd3, 5'd2}: r = {4'd14, 2'd1};
      {2'd3, 5'd3}: r = {4'd2,  2'd0};
      default:      r = {4'hF,  2'd0};
    endcase
    return r;
  endfunction

  logic [5:0]    entry;
  logic [3:0]    entry_note;
  logic [1:0]    entry_dur;
  logic          is_end;
  logic [CW-1:0] play_len;
  logic [CW-1:0] gap_last;

  assign entry      = rom_entry(song_idx, addr);
  assign entry_note = entry[5:2];
  assign entry_dur  = entry[1:0];
  assign is_end     = (entry_note == 4'hF) || (addr == 5'd31);
  assign gap_last   = CW'(GAP_TICKS - 1);

  // Sounding part of the note: whole beats minus the closing gap.
  always_comb begin
    play_len = CW'(TICKS_PER_BEAT - GAP_TICKS);
    case (entry_dur)
      2'd0: play_len = CW'(TICKS_PER_BEAT - GAP_TICKS);
      2'd1: play_len = CW'(2 * TICKS_PER_BEAT - GAP_TICKS);
      2'd2: play_len = CW'(3 * TICKS_PER_BEAT - GAP_TICKS);
      2'd3: play_len = CW'(4 * TICKS_PER_BEAT - GAP_TICKS);
      default: play_len = CW'(TICKS_PER_BEAT - GAP_TICKS);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr     <= 5'd0;
      cnt      <= '0;
      note_out <= 4'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      cnt      <= cnt_nx;
      note_out <= note_nx;
      done     <= done_nx;
    end
  end

  // note_nx is the note for the next cycle; it is only non-zero while a
  // real note is sounding in PLAY, so leaving PLAY silences the buzzer.
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    cnt_nx   = cnt;
    note_nx  = 4'd0;
    done_nx  = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      addr_nx  = 5'd0;
      cnt_nx   = '0;
    end else if (change) begin
      // A song change aborts whatever is playing and starts the new song.
      state_nx = S_PLAY;
      addr_nx  = 5'd0;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_PLAY;
          addr_nx  = 5'd0;
          cnt_nx   = '0;
        end
        S_PLAY: begin
          if (is_end) begin
`ifdef SONG_LOOP_EN
            state_nx = S_PLAY;
            addr_nx  = 5'd0;
            cnt_nx   = '0;
`else
            state_nx = S_DONE;
            done_nx  = 1'b1;
`endif
          end else begin
            note_nx = (entry_note <= 4'd7) ? entry_note : 4'd0;
            if (cnt == play_len - CW'(1)) begin
              state_nx = S_GAP;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        S_GAP: begin
          if (cnt == gap_last) begin
            state_nx = S_PLAY;
            addr_nx  = addr + 5'd1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_DONE: begin
          state_nx = S_DONE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    led_out = 7'd0;
    if (note_out != 4'd0 && note_out <= 4'd7) begin
      led_out = 7'd1 << (note_out[2:0] - 3'd1);
    end
  end

  assign playing   = (state == S_PLAY) || (state == S_GAP);
  assign state_dbg = state;

endmodule

// File: tb/tb_song_player.sv
// ---------------------------------------------------------------------------
// tb_song_player
//
// Directed bench for song_player with TICKS_PER_BEAT=8, GAP_TICKS=2.
// The reference model describes playback as "song s started at edge e":
// the expected note at any later edge is found by walking the song's
// durations. Button, enable and reset actions replace the current playback
// segment, effective from the edge at which the design must react.
// ---------------------------------------------------------------------------
module tb_song_player;

  localparam int T = 8;
  localparam int G = 2;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] song_select;
  logic [3:0] note_out;
  logic [6:0] led_out;
  logic [1:0] song_idx;
  logic       playing;
  logic       done;
  logic [1:0] state_dbg;

  song_player #(.TICKS_PER_BEAT(T), .GAP_TICKS(G)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .song_select (song_select),
    .note_out    (note_out),
    .led_out     (led_out),
    .song_idx    (song_idx),
    .playing     (playing),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- song table (notes, dur fields) ----------------
  int rom_n [4][8] = '{'{3, 5, 1, 7, 15, 15, 15, 15},
                       '{2, 4, 15, 15, 15, 15, 15, 15},
                       '{9, 6, 8, 1, 15, 15, 15, 15},
                       '{5, 7, 14, 2, 15, 15, 15, 15}};
  int rom_d [4][8] = '{'{1, 0, 0, 2, 0, 0, 0, 0},
                       '{0, 0, 0, 0, 0, 0, 0, 0},
                       '{0, 1, 0, 0, 0, 0, 0, 0},
                       '{0, 3, 1, 0, 0, 0, 0, 0}};

  // ---------------- model ----------------
  typedef struct {
    bit       active;
    bit [1:0] song;
    int       e;
  } seg_t;

  seg_t cur  = '{1'b0, 2'd0, 0};
  seg_t prev = '{1'b0, 2'd0, 0};

  function automatic int map_note(input int n);
    return (n >= 1 && n <= 7) ? n : 0;
  endfunction

  function automatic int song_total(input int s);
    int t;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      if (rom_n[s][i] == 15) break;
      t += (rom_d[s][i] + 1) * T;
    end
    return t;
  endfunction

  function automatic int note_at(input int s, input int o);
    int rem;
    int len;
    rem = o;
    for (int i = 0; i < 8; i++) begin
      if (rom_n[s][i] == 15) return 0;
      len = (rom_d[s][i] + 1) * T;
      if (rem < len - G) return map_note(rom_n[s][i]);
      if (rem < len) return 0;
      rem -= len;
    end
    return 0;
  endfunction

  task automatic model_out(input int k, output int n, output int p,
                           output int d, output int s);
    seg_t sg;
    int rel, tot;
    sg = (k >= cur.e) ? cur : prev;
    s = int'(sg.song);
    n = 0; p = 0; d = 0;
    if (sg.active) begin
      rel = k - sg.e;
      tot = song_total(s);
      if (rel >= 0) begin
`ifdef SONG_LOOP_EN
        p = 1;
        if (rel >= 1 && ((rel - 1) % (tot + 1)) < tot)
          n = note_at(s, (rel - 1) % (tot + 1));
`else
        p = (rel <= tot) ? 1 : 0;
        d = (rel == tot + 1) ? 1 : 0;
        if (rel >= 1 && rel - 1 < tot) n = note_at(s, rel - 1);
`endif
      end
    end
  endtask

  function automatic int led_of(input int n);
    return (n >= 1 && n <= 7) ? (1 << (n - 1)) : 0;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: compare all outputs against the model.
  always @(negedge clk) begin
    int en, ep, ed, es;
    model_out(cyc, en, ep, ed, es);
    chk("note_out", int'(note_out), en);
    chk("led_out",  int'(led_out),  led_of(en));
    chk("playing",  int'(playing),  ep);
    chk("done",     int'(done),     ed);
    chk("song_idx", int'(song_idx), es);
  end

  // ---------------- driver tasks ----------------
  task automatic at_edge(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] bits, output int e);
    @(posedge clk);
    #1;
    song_select = bits;
    e = cyc + 3;
    if (bits == 2'b10 || bits == 2'b01) begin
      prev = cur;
      cur.song   = bits[1] ? cur.song + 2'd1 : cur.song - 2'd1;
      cur.active = enable;
      cur.e      = e;
    end
  endtask

  task automatic release_sel();
    @(posedge clk);
    #1;
    song_select = 2'b00;
    repeat (4) @(posedge clk);
  endtask

  task automatic set_enable(input logic v, output int e);
    @(posedge clk);
    #1;
    enable = v;
    e = cyc + 1;
    prev = cur;
    cur.active = v;
    cur.e      = e;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, e1, e2, e3, e4, e5, e6, e7, e8, eb, t;
    reset = 1'b0;
    enable = 1'b1;
    song_select = 2'b00;
    repeat (3) @(posedge clk);

    // Release reset with enable already high: song 0 from entry 0.
    #1;
    reset = 1'b1;
    e0 = cyc + 1;
    prev = cur;
    cur = '{1'b1, 2'd0, e0};

    at_edge(e0 + 1);  chk("s0_first_note", int'(note_out), 3);
    at_edge(e0 + 14); chk("s0_note_last", int'(note_out), 3);
    at_edge(e0 + 15); chk("s0_gap_a", int'(note_out), 0);
    at_edge(e0 + 16); chk("s0_gap_b", int'(note_out), 0);
    at_edge(e0 + 17);
    chk("s0_entry1", int'(note_out), 5);
    chk("led_for_5", int'(led_out), 16);
`ifdef SONG_LOOP_EN
    at_edge(e0 + 57); chk("s0_loop_done", int'(done), 0);
    at_edge(e0 + 58); chk("s0_loop_note", int'(note_out), 3);
`else
    at_edge(e0 + 57); chk("s0_done_pulse", int'(done), 1);
    at_edge(e0 + 58);
    chk("s0_done_low", int'(done), 0);
    chk("s0_stopped", int'(playing), 0);
`endif
    at_edge(e0 + 62);

    // Next: song 1 (two notes then marker).
    press(2'b10, e1);
    at_edge(e1);      chk("s1_idx", int'(song_idx), 1);
    at_edge(e1 + 1);  chk("s1_first", int'(note_out), 2);
    at_edge(e1 + 16); chk("s1_pre_done", int'(done), 0);
`ifdef SONG_LOOP_EN
    at_edge(e1 + 17); chk("s1_no_done", int'(done), 0);
    at_edge(e1 + 18); chk("s1_repeat", int'(note_out), 2);
`else
    at_edge(e1 + 17); chk("s1_done", int'(done), 1);
    at_edge(e1 + 18); chk("s1_done_once", int'(done), 0);
`endif
    release_sel();

    // Next: song 2, first entry is a ROM rest (note 9).
    press(2'b10, e2);
    at_edge(e2 + 1);
    chk("s2_rest_note", int'(note_out), 0);
    chk("s2_rest_led", int'(led_out), 0);
    at_edge(e2 + 8);  chk("s2_rest_end", int'(note_out), 0);
    at_edge(e2 + 9);  chk("s2_entry1", int'(note_out), 6);
    release_sel();

    // Next: 2 -> 3, then 3 -> 0 wraps and restarts song 0.
    press(2'b10, e3);
    release_sel();
    press(2'b10, e4);
    at_edge(e4);      chk("wrap_idx0", int'(song_idx), 0);
    at_edge(e4 + 1);  chk("wrap_restart", int'(note_out), 3);
    release_sel();

    // Prev: 0 -> 3.
    press(2'b01, e5);
    at_edge(e5);      chk("prev_idx3", int'(song_idx), 3);
    release_sel();

    // Both buttons together: ignored.
    press(2'b11, eb);
    at_edge(eb + 2);  chk("both_ignored", int'(song_idx), 3);
    release_sel();

    // Drop enable mid-note, then re-enable: entry 0 replayed.
    set_enable(1'b0, t);
    at_edge(t);
    chk("dis_note", int'(note_out), 0);
    chk("dis_playing", int'(playing), 0);
    repeat (3) @(posedge clk);
    set_enable(1'b1, e6);
    at_edge(e6 + 1);
    chk("reen_note", int'(note_out), 5);
    chk("reen_led", int'(led_out), 16);
    at_edge(e6 + 8);

    // Prev: 3 -> 2, then reset during the gap of entry 0.
    press(2'b01, e7);
    release_sel();
    at_edge(e7 + 6);
    #2;
    reset = 1'b0;
    prev = '{1'b0, 2'd0, cyc};
    cur  = '{1'b0, 2'd0, cyc};
    #1;
    chk("rst_note", int'(note_out), 0);
    chk("rst_led", int'(led_out), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(song_idx), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    e8 = cyc + 1;
    prev = cur;
    cur = '{1'b1, 2'd0, e8};
    at_edge(e8 + 1);
    chk("post_rst_note", int'(note_out), 3);
    chk("post_rst_idx", int'(song_idx), 0);
    at_edge(e8 + 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
